alu_op_issue: RTL and testbench

// - Producer side of the ALU Operation interface: takes decoded instruction fields, encodes the 4-bit Operation, selects SrcA/SrcB.
// - Sits between decode and execute; a 2-entry registered skid buffer with valid/ready on both sides decouples the stages.
// - Output drives the ALU SrcA/SrcB/Operation inputs directly, plus illegal and branch flags.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_skid.sv | 90 +++++++++
 rtl/alu_op_issue.sv | 144 ++++++++++++++
 tb/tb_alu_op_issue.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation issue stage: ALU op codes and RV32I major opcodes.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
    localparam int unsigned DEFAULT_OPCODE_LENGTH = 4;

    typedef enum logic [3:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluSll = 4'b0011,
        AluSrl = 4'b0100,
        AluSub = 4'b0101,
        AluSra = 4'b0110,
        AluSlt = 4'b0111,
        AluEq  = 4'b1000,
        AluNe  = 4'b1001,
        AluLt  = 4'b1010,
        AluGe  = 4'b1011,
        AluXor = 4'b1100,
        AluLui = 4'b1101
    } alu_op_t;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry registered valid/ready buffer. The head entry register drives the output directly,
// so the payload only changes when the head is consumed or the buffer was empty.
module alu_issue_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    localparam logic [1:0] Empty = 2'd0;
    localparam logic [1:0] One   = 2'd1;
    localparam logic [1:0] Full  = 2'd2;

    logic [1:0]       count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             push, pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = Empty;
        end else begin
            case (count_q)
                Empty: begin
                    if (push) begin
                        head_d  = in_data_i;
                        count_d = One;
                    end
                end
                One: begin
                    case ({push, pop})
                        2'b11: head_d = in_data_i;
                        2'b10: begin
                            tail_d  = in_data_i;
                            count_d = Full;
                        end
                        2'b01: count_d = Empty;
                        default: ;
                    endcase
                end
                Full: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = One;
                    end
                end
                default: count_d = Empty;
            endcase
        end
        in_ready_d  = (count_d != Full);
        out_valid_d = (count_d != Empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= Empty;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/alu_op_issue.sv
// Decode-to-execute issue stage: encodes the ALU operation and operands from decoded fields and
// hands them to execute through a registered two-entry buffer.
module alu_op_issue #(
    parameter int unsigned DATA_WIDTH    = alu_pkg::DEFAULT_DATA_WIDTH,
    parameter int unsigned OPCODE_LENGTH = alu_pkg::DEFAULT_OPCODE_LENGTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [DATA_WIDTH-1:0]    in_rs1,
    input  logic [DATA_WIDTH-1:0]    in_rs2,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_branch,
    output logic                     out_illegal
);

    import alu_pkg::*;

    localparam int unsigned PayloadW = OPCODE_LENGTH + 2 * DATA_WIDTH + 2;

    alu_op_t                  enc_op;
    logic [DATA_WIDTH-1:0]    enc_a, enc_b, shamt;
    logic                     enc_branch, enc_illegal;
    logic [OPCODE_LENGTH-1:0] enc_op_bits;
    logic [PayloadW-1:0]      in_data, out_data;

    assign shamt = {{(DATA_WIDTH - 5){1'b0}}, in_imm[4:0]};

    always_comb begin
        enc_op      = AluAnd;
        enc_a       = '0;
        enc_b       = '0;
        enc_branch  = 1'b0;
        enc_illegal = 1'b0;
        case (in_opcode)
            OpcOp: begin
                enc_a = in_rs1;
                enc_b = in_rs2;
                case (in_funct3)
                    3'b000:  enc_op = in_funct7[5] ? AluSub : AluAdd;
                    3'b001:  enc_op = AluSll;
                    3'b010:  enc_op = AluSlt;
                    3'b100:  enc_op = AluXor;
                    3'b101:  enc_op = in_funct7[5] ? AluSra : AluSrl;
                    3'b110:  enc_op = AluOr;
                    3'b111:  enc_op = AluAnd;
                    default: enc_illegal = 1'b1;
                endcase
            end
            OpcOpImm: begin
                enc_a = in_rs1;
                enc_b = in_imm;
                case (in_funct3)
                    3'b000: enc_op = AluAdd;
                    3'b001: begin
                        enc_op      = AluSll;
                        enc_b       = shamt;
                        enc_illegal = (in_funct7 != 7'b0);
                    end
                    3'b010: enc_op = AluSlt;
                    3'b100: enc_op = AluXor;
                    3'b101: begin
                        enc_op = in_funct7[5] ? AluSra : AluSrl;
                        enc_b  = shamt;
                    end
                    3'b110:  enc_op = AluOr;
                    3'b111:  enc_op = AluAnd;
                    default: enc_illegal = 1'b1;
                endcase
            end
            OpcLoad, OpcStore: begin
                enc_op = AluAdd;
                enc_a  = in_rs1;
                enc_b  = in_imm;
            end
            OpcBranch: begin
                enc_a      = in_rs1;
                enc_b      = in_rs2;
                enc_branch = 1'b1;
                case (in_funct3)
                    3'b000:  enc_op = AluEq;
                    3'b001:  enc_op = AluNe;
                    3'b100:  enc_op = AluLt;
                    3'b101:  enc_op = AluGe;
                    default: enc_illegal = 1'b1;
                endcase
            end
            OpcLui: begin
                enc_op = AluLui;
                enc_b  = in_imm;
            end
            OpcAuipc: begin
                enc_op = AluAdd;
                enc_a  = in_pc;
                enc_b  = in_imm;
            end
            OpcJal, OpcJalr: begin
                // ALU computes the link address pc + 4
                enc_op = AluAdd;
                enc_a  = in_pc;
                enc_b  = DATA_WIDTH'(4);
            end
            default: enc_illegal = 1'b1;
        endcase
        // Illegal entries still flow downstream but carry a clean zero payload
        if (enc_illegal) begin
            enc_op     = AluAnd;
            enc_a      = '0;
            enc_b      = '0;
            enc_branch = 1'b0;
        end
    end

    assign enc_op_bits = OPCODE_LENGTH'(enc_op);
    assign in_data     = {enc_op_bits, enc_a, enc_b, enc_branch, enc_illegal};

    alu_issue_skid #(
        .Width(PayloadW)
    ) u_skid (
        .clk_i      (clk),
        .rst_i      (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
    );

    assign {Operation, SrcA, SrcB, out_branch, out_illegal} = out_data;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue: encoding table, backpressure, flush and reset.
module tb_alu_op_issue;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  in_opcode, in_funct7;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc, SrcA, SrcB;
    logic [3:0]  Operation;
    logic        out_branch, out_illegal;

    int errors = 0;
    int checks = 0;

    // {out_valid, in_ready, Operation, SrcA, SrcB, out_branch, out_illegal}
    logic [71:0] obs, exp_v;
    assign obs = {out_valid, in_ready, Operation, SrcA, SrcB, out_branch, out_illegal};

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        ill;
    } vec_t;

    alu_op_issue #(
        .DATA_WIDTH   (32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Operation  (Operation),
        .out_branch (out_branch),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] pc);
        in_opcode = opc;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_pc     = pc;
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic br, input logic ill);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.op = op; v.a = a; v.b = b; v.br = br; v.ill = ill;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0);
        step();
        step();
        checks++;
        exp_v = {1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    // Back-to-back stream with out_ready high: each cycle shows the entry pushed one edge earlier
    task automatic test_encode();
        vec_t vecs[$];
        logic [31:0] m;
        m = 32'hFFFF_FF85;
        vecs.push_back(mk(7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, m, 32'h400,
                          4'h2, 32'd5, 32'd7, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b000, 7'h20, 32'h11, 32'h22, m, 32'h400,
                          4'h5, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b001, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h3, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b010, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h7, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b100, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'hC, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b101, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h4, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b101, 7'h20, 32'h11, 32'h22, m, 32'h400,
                          4'h6, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b110, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h1, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0110011, 3'b111, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h11, 32'h22, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 3'b000, 7'h7C, 32'h11, 32'h22, m, 32'h400,
                          4'h2, 32'h11, m, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 3'b101, 7'h20, 32'h8000_0000, 32'h22, 32'h405, 32'h400,
                          4'h6, 32'h8000_0000, 32'd5, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 3'b001, 7'h00, 32'h11, 32'h22, 32'h3, 32'h400,
                          4'h3, 32'h11, 32'd3, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010011, 3'b111, 7'h7C, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h11, m, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0000011, 3'b010, 7'h00, 32'h11, 32'h22, 32'h8, 32'h400,
                          4'h2, 32'h11, 32'h8, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0100011, 3'b010, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h2, 32'h11, m, 1'b0, 1'b0));
        vecs.push_back(mk(7'b1100011, 3'b000, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h8, 32'h11, 32'h22, 1'b1, 1'b0));
        vecs.push_back(mk(7'b1100011, 3'b001, 7'h00, 32'd3, 32'd4, m, 32'h400,
                          4'h9, 32'd3, 32'd4, 1'b1, 1'b0));
        vecs.push_back(mk(7'b1100011, 3'b100, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'hA, 32'h11, 32'h22, 1'b1, 1'b0));
        vecs.push_back(mk(7'b1100011, 3'b101, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'hB, 32'h11, 32'h22, 1'b1, 1'b0));
        vecs.push_back(mk(7'b0110111, 3'b000, 7'h00, 32'h11, 32'h22, 32'h1234_5000, 32'h400,
                          4'hD, 32'h0, 32'h1234_5000, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0010111, 3'b000, 7'h00, 32'h11, 32'h22, 32'h2000, 32'h100,
                          4'h2, 32'h100, 32'h2000, 1'b0, 1'b0));
        vecs.push_back(mk(7'b1101111, 3'b000, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h2, 32'h400, 32'd4, 1'b0, 1'b0));
        vecs.push_back(mk(7'b1100111, 3'b000, 7'h00, 32'h11, 32'h22, m, 32'h800,
                          4'h2, 32'h800, 32'd4, 1'b0, 1'b0));
        vecs.push_back(mk(7'b0001111, 3'b000, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(7'b0110011, 3'b011, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(7'b0010011, 3'b011, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(7'b0010011, 3'b001, 7'h01, 32'h11, 32'h22, 32'h23, 32'h400,
                          4'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        vecs.push_back(mk(7'b1100011, 3'b010, 7'h00, 32'h11, 32'h22, m, 32'h400,
                          4'h0, 32'h0, 32'h0, 1'b0, 1'b1));

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            set_in(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].imm, vecs[i].pc);
            in_valid = 1'b1;
            step();
            checks++;
            exp_v = {1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].ill};
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL encode_vec%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL encode_drain: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd1, 32'h10, 32'd0, 32'd0);
        step();
        checks++;
        exp_v = {1'b1, 1'b1, 4'h2, 32'd1, 32'h10, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_first: got %h expected %h", obs, exp_v);
        end
        set_in(7'b0110011, 3'b000, 7'h00, 32'd2, 32'h10, 32'd0, 32'd0);
        step();
        checks++;
        exp_v = {1'b1, 1'b0, 4'h2, 32'd1, 32'h10, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_full: got %h expected %h", obs, exp_v);
        end
        set_in(7'b0110011, 3'b000, 7'h00, 32'd3, 32'h10, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", k, obs, exp_v);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        exp_v = {1'b1, 1'b1, 4'h2, 32'd2, 32'h10, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_drain2: got %h expected %h", obs, exp_v);
        end
        step();
        checks++;
        exp_v = {1'b1, 1'b1, 4'h2, 32'd3, 32'h10, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_drain3: got %h expected %h", obs, exp_v);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_empty: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd1, 32'h10, 32'd0, 32'd0);
        step();
        set_in(7'b0110011, 3'b000, 7'h00, 32'd2, 32'h10, 32'd0, 32'd0);
        step();
        flush = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd3, 32'h10, 32'd0, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL flush_full%0d: got %b expected 01", k, {out_valid, in_ready});
            end
            step();
        end
        // One buffered entry plus an offered entry in the flush cycle: both must vanish
        in_valid = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd4, 32'h10, 32'd0, 32'd0);
        step();
        flush = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd5, 32'h10, 32'd0, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL flush_drop%0d: got %b expected 01", k, {out_valid, in_ready});
            end
            step();
        end
        out_ready = 1'b1; in_valid = 1'b1;
        set_in(7'b0110011, 3'b000, 7'h00, 32'd6, 32'h10, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        checks++;
        exp_v = {1'b1, 1'b1, 4'h2, 32'd6, 32'h10, 1'b0, 1'b0};
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL flush_resume: got %h expected %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(7'b1100011, 3'b001, 7'h00, 32'd3, 32'd4, 32'd0, 32'd0);
        step();
        set_in(7'b0010111, 3'b000, 7'h00, 32'd0, 32'd0, 32'h2000, 32'h100);
        step();
        reset = 1'b1; flush = 1'b1;
        step();
        exp_v = {1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_after: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
